// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch sequencer: tracks each warp from launch through fetch, decode
// feedback and drain, and round-robin picks the next warp to fetch.
module warp_fetch_scheduler #(
    parameter int NumWarps  = 8,
    parameter int PcWidth   = 32,
    parameter int WarpWidth = 32,
    parameter int WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 launch_valid_i,
    output logic                 launch_ready_o,
    input  logic [WidWidth-1:0]  launch_warp_id_i,
    input  logic [PcWidth-1:0]   launch_pc_i,
    input  logic [WarpWidth-1:0] launch_act_mask_i,
    input  logic [NumWarps-1:0]  ib_space_available_i,
    input  logic [NumWarps-1:0]  ib_all_instr_finished_i,
    output logic                 fe_valid_o,
    input  logic                 fe_ready_i,
    output logic [WidWidth-1:0]  fe_warp_id_o,
    output logic [PcWidth-1:0]   fe_pc_o,
    output logic [WarpWidth-1:0] fe_act_mask_o,
    input  logic                 dec_valid_i,
    input  logic [WidWidth-1:0]  dec_warp_id_i,
    input  logic [PcWidth-1:0]   dec_next_pc_i,
    input  logic [WarpWidth-1:0] dec_act_mask_i,
    input  logic                 dec_stop_i,
    output logic [NumWarps-1:0]  warp_done_o,
    output logic                 busy_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] READY    = 2'd1;
    localparam logic [1:0] WAIT_DEC = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    logic [1:0]           state    [NumWarps];
    logic [PcWidth-1:0]   pc       [NumWarps];
    logic [WarpWidth-1:0] act_mask [NumWarps];

    logic [WidWidth-1:0] rr_ptr;
    logic [WidWidth-1:0] lock_wid;
    logic [WidWidth-1:0] winner;
    logic [WidWidth-1:0] sel_wid;
    logic [WidWidth:0]   scan_idx;
    logic                lock;
    logic                any_eligible;
    logic                fe_fire;
    logic                launch_fire;
    logic [NumWarps-1:0] eligible;
    logic [NumWarps-1:0] not_idle;
    logic [NumWarps-1:0] done_q;

    always_comb begin
        eligible = '0;
        not_idle = '0;
        for (int w = 0; w < NumWarps; w++) begin
            eligible[w] = (state[w] == READY) && ib_space_available_i[w];
            not_idle[w] = (state[w] != IDLE);
        end
    end

    // NOTE: combinational scan uses blocking '=' so each iteration sees the
    // previous one's result; registers below use '<=' exclusively.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        scan_idx     = '0;
        for (int i = 0; i < NumWarps; i++) begin
            scan_idx = {1'b0, rr_ptr} + (WidWidth+1)'(i);
            if (scan_idx >= (WidWidth+1)'(NumWarps))
                scan_idx = scan_idx - (WidWidth+1)'(NumWarps);
            if (!any_eligible && eligible[scan_idx[WidWidth-1:0]]) begin
                any_eligible = 1'b1;
                winner       = scan_idx[WidWidth-1:0];
            end
        end
    end

    // A locked request keeps presenting the same warp until the fetcher takes it.
    assign sel_wid        = lock ? lock_wid : winner;
    assign fe_valid_o     = lock | any_eligible;
    assign fe_warp_id_o   = sel_wid;
    assign fe_pc_o        = pc[sel_wid];
    assign fe_act_mask_o  = act_mask[sel_wid];
    assign fe_fire        = fe_valid_o & fe_ready_i;
    assign launch_ready_o = (int'(launch_warp_id_i) < NumWarps) &&
                            (state[launch_warp_id_i] == IDLE);
    assign launch_fire    = launch_valid_i & launch_ready_o;
    assign warp_done_o    = done_q;
    assign busy_o         = |not_idle;

    // NOTE: the per-warp pc/mask arrays are reset too, since a reset-idle
    // scheduler must present zero fetch data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < NumWarps; w++) begin
                state[w]    <= IDLE;
                pc[w]       <= '0;
                act_mask[w] <= '0;
            end
            done_q   <= '0;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_wid <= '0;
        end else begin
            for (int w = 0; w < NumWarps; w++) begin
                done_q[w] <= 1'b0;
                case (state[w])
                    IDLE: begin
                        if (launch_fire && launch_warp_id_i == WidWidth'(w)) begin
                            state[w]    <= READY;
                            pc[w]       <= launch_pc_i;
                            act_mask[w] <= launch_act_mask_i;
                        end
                    end
                    READY: begin
                        if (fe_fire && sel_wid == WidWidth'(w))
                            state[w] <= WAIT_DEC;
                    end
                    WAIT_DEC: begin
                        if (dec_valid_i && dec_warp_id_i == WidWidth'(w)) begin
                            if (dec_stop_i) begin
                                state[w] <= DRAIN;
                            end else begin
                                state[w]    <= READY;
                                pc[w]       <= dec_next_pc_i;
                                act_mask[w] <= dec_act_mask_i;
                            end
                        end
                    end
                    default: begin
                        if (ib_all_instr_finished_i[w]) begin
                            state[w]  <= IDLE;
                            done_q[w] <= 1'b1;
                        end
                    end
                endcase
            end

            if (fe_fire) begin
                lock   <= 1'b0;
                rr_ptr <= (int'(sel_wid) == NumWarps - 1) ? '0 : sel_wid + WidWidth'(1);
            end else if (fe_valid_o) begin
                lock     <= 1'b1;
                lock_wid <= sel_wid;
            end
        end
    end

`ifndef SYNTHESIS
    // Decode feedback is only meaningful for a warp waiting on it.
    a_dec_target_waiting: assert property (@(posedge clk_i) disable iff (rst_i)
        dec_valid_i |-> (state[dec_warp_id_i] == WAIT_DEC));
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed bench for warp_fetch_scheduler: launch, round-robin order, lock
// stability, decode feedback, drain/done pulse, ib backpressure and reset.
module tb_warp_fetch_scheduler;

    localparam int NW = 8;
    localparam int PW = 32;
    localparam int WW = 32;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          launch_valid_i;
    logic          launch_ready_o;
    logic [IW-1:0] launch_warp_id_i;
    logic [PW-1:0] launch_pc_i;
    logic [WW-1:0] launch_act_mask_i;
    logic [NW-1:0] ib_space_available_i;
    logic [NW-1:0] ib_all_instr_finished_i;
    logic          fe_valid_o;
    logic          fe_ready_i;
    logic [IW-1:0] fe_warp_id_o;
    logic [PW-1:0] fe_pc_o;
    logic [WW-1:0] fe_act_mask_o;
    logic          dec_valid_i;
    logic [IW-1:0] dec_warp_id_i;
    logic [PW-1:0] dec_next_pc_i;
    logic [WW-1:0] dec_act_mask_i;
    logic          dec_stop_i;
    logic [NW-1:0] warp_done_o;
    logic          busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    warp_fetch_scheduler #(.NumWarps(NW), .PcWidth(PW), .WarpWidth(WW)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .launch_valid_i          (launch_valid_i),
        .launch_ready_o          (launch_ready_o),
        .launch_warp_id_i        (launch_warp_id_i),
        .launch_pc_i             (launch_pc_i),
        .launch_act_mask_i       (launch_act_mask_i),
        .ib_space_available_i    (ib_space_available_i),
        .ib_all_instr_finished_i (ib_all_instr_finished_i),
        .fe_valid_o              (fe_valid_o),
        .fe_ready_i              (fe_ready_i),
        .fe_warp_id_o            (fe_warp_id_o),
        .fe_pc_o                 (fe_pc_o),
        .fe_act_mask_o           (fe_act_mask_o),
        .dec_valid_i             (dec_valid_i),
        .dec_warp_id_i           (dec_warp_id_i),
        .dec_next_pc_i           (dec_next_pc_i),
        .dec_act_mask_i          (dec_act_mask_i),
        .dec_stop_i              (dec_stop_i),
        .warp_done_o             (warp_done_o),
        .busy_o                  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        else
            n_pass++;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic launch(input logic [IW-1:0] wid, input logic [PW-1:0] pc, input logic [WW-1:0] mask);
        launch_valid_i    = 1'b1;
        launch_warp_id_i  = wid;
        launch_pc_i       = pc;
        launch_act_mask_i = mask;
    endtask

    task automatic dec(input logic [IW-1:0] wid, input logic [PW-1:0] pc, input logic [WW-1:0] mask, input logic stop);
        dec_valid_i    = 1'b1;
        dec_warp_id_i  = wid;
        dec_next_pc_i  = pc;
        dec_act_mask_i = mask;
        dec_stop_i     = stop;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] order [6];
        order = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};

        rst_i                   = 1'b1;
        launch_valid_i          = 1'b0;
        launch_warp_id_i        = '0;
        launch_pc_i             = '0;
        launch_act_mask_i       = '0;
        ib_space_available_i    = '1;
        ib_all_instr_finished_i = '1;
        fe_ready_i              = 1'b0;
        dec_valid_i             = 1'b0;
        dec_warp_id_i           = '0;
        dec_next_pc_i           = '0;
        dec_act_mask_i          = '0;
        dec_stop_i              = 1'b0;

        // Reset state
        #12;
        check("rst_fe_valid", 64'(fe_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(warp_done_o), 64'd0);
        check("rst_launch_ready", 64'(launch_ready_o), 64'd1);
        check("rst_fe_pc", 64'(fe_pc_o), 64'd0);
        check("rst_fe_wid", 64'(fe_warp_id_o), 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Launch warp 2, single fetch
        fe_ready_i = 1'b1;
        launch(3'd2, 32'h100, 32'hFFFF_FFFF);
        settle();
        check("l2_launch_ready", 64'(launch_ready_o), 64'd1);
        tick();
        launch_valid_i = 1'b0;
        settle();
        check("l2_fe_valid", 64'(fe_valid_o), 64'd1);
        check("l2_fe_wid", 64'(fe_warp_id_o), 64'd2);
        check("l2_fe_pc", 64'(fe_pc_o), 64'h100);
        check("l2_fe_mask", 64'(fe_act_mask_o), 64'hFFFF_FFFF);
        check("l2_busy", 64'(busy_o), 64'd1);
        tick();
        settle();
        check("l2_fe_valid_after", 64'(fe_valid_o), 64'd0);
        check("l2_launch_ready_busy", 64'(launch_ready_o), 64'd0);

        // Decode return without stop, refetch at next PC
        dec(3'd2, 32'h104, 32'h0000_FFFF, 1'b0);
        tick();
        dec_valid_i = 1'b0;
        settle();
        check("d2_fe_valid", 64'(fe_valid_o), 64'd1);
        check("d2_fe_pc", 64'(fe_pc_o), 64'h104);
        check("d2_fe_mask", 64'(fe_act_mask_o), 64'h0000_FFFF);
        tick();

        // Stop, then drain for 4 cycles
        ib_all_instr_finished_i[2] = 1'b0;
        dec(3'd2, 32'h200, 32'h0, 1'b1);
        tick();
        dec_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("drain_done", 64'(warp_done_o), 64'd0);
            check("drain_launch_ready", 64'(launch_ready_o), 64'd0);
            check("drain_fe_valid", 64'(fe_valid_o), 64'd0);
            tick();
        end
        ib_all_instr_finished_i[2] = 1'b1;
        settle();
        check("drain_done_pre", 64'(warp_done_o), 64'd0);
        tick();
        settle();
        check("drain_done_pulse", 64'(warp_done_o), 64'h04);
        check("drain_launch_ready_back", 64'(launch_ready_o), 64'd1);
        check("drain_busy", 64'(busy_o), 64'd0);
        tick();
        settle();
        check("drain_done_clear", 64'(warp_done_o), 64'd0);

        // Round robin among warps 0, 1, 3 (rr_ptr = 3 here)
        fe_ready_i = 1'b0;
        launch(3'd0, 32'h10, 32'h1);
        tick();
        launch(3'd1, 32'h20, 32'h2);
        tick();
        launch(3'd3, 32'h30, 32'h8);
        tick();
        launch_valid_i = 1'b0;
        fe_ready_i     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0)
                dec(order[i-1], 32'h1000 + 32'(order[i-1]) * 32'h10, 32'hF, i >= 4);
            settle();
            check("rr_fe_valid", 64'(fe_valid_o), 64'd1);
            check("rr_fe_wid", 64'(fe_warp_id_o), 64'(order[i]));
            if (i == 0) check("rr_pc0", 64'(fe_pc_o), 64'h10);
            if (i == 3) check("rr_pc3", 64'(fe_pc_o), 64'h1000);
            tick();
            dec_valid_i = 1'b0;
        end
        fe_ready_i = 1'b0;
        dec(3'd3, 32'h0, 32'h0, 1'b1);
        settle();
        check("rr_none_ready", 64'(fe_valid_o), 64'd0);
        tick();
        dec_valid_i = 1'b0;
        settle();
        check("rr_done_w1", 64'(warp_done_o), 64'h02);
        tick();
        settle();
        check("rr_done_w3", 64'(warp_done_o), 64'h08);
        check("rr_busy", 64'(busy_o), 64'd0);

        // Lock stability: warp 5 held for 3 cycles while warp 1 becomes eligible
        launch(3'd5, 32'h500, 32'hA5A5_0000);
        tick();
        launch(3'd1, 32'h1A0, 32'h1);
        settle();
        check("lk_wid_c1", 64'(fe_warp_id_o), 64'd5);
        check("lk_pc_c1", 64'(fe_pc_o), 64'h500);
        tick();
        launch_valid_i          = 1'b0;
        ib_space_available_i[5] = 1'b0;
        settle();
        check("lk_valid_c2", 64'(fe_valid_o), 64'd1);
        check("lk_wid_c2", 64'(fe_warp_id_o), 64'd5);
        check("lk_pc_c2", 64'(fe_pc_o), 64'h500);
        tick();
        settle();
        check("lk_wid_c3", 64'(fe_warp_id_o), 64'd5);
        check("lk_mask_c3", 64'(fe_act_mask_o), 64'hA5A5_0000);
        tick();
        ib_space_available_i[5] = 1'b1;
        fe_ready_i              = 1'b1;
        settle();
        check("lk_wid_hs", 64'(fe_warp_id_o), 64'd5);
        tick();
        settle();
        check("lk_next_wid", 64'(fe_warp_id_o), 64'd1);
        check("lk_next_pc", 64'(fe_pc_o), 64'h1A0);
        tick();
        settle();
        check("lk_idle", 64'(fe_valid_o), 64'd0);
        dec(3'd5, 32'h0, 32'h0, 1'b1);
        tick();
        dec(3'd1, 32'h0, 32'h0, 1'b1);
        tick();
        dec_valid_i = 1'b0;
        tick();
        settle();
        check("lk_busy", 64'(busy_o), 64'd0);

        // IB backpressure on warp 4 (rr_ptr = 2 here)
        ib_space_available_i[4] = 1'b0;
        launch(3'd4, 32'h400, 32'h44);
        tick();
        launch(3'd6, 32'h600, 32'h66);
        settle();
        check("ib_no_w4", 64'(fe_valid_o), 64'd0);
        check("ib_busy", 64'(busy_o), 64'd1);
        tick();
        launch_valid_i = 1'b0;
        settle();
        check("ib_w6_wid", 64'(fe_warp_id_o), 64'd6);
        tick();
        settle();
        check("ib_w4_blocked", 64'(fe_valid_o), 64'd0);
        dec(3'd6, 32'h604, 32'h66, 1'b0);
        tick();
        dec_valid_i             = 1'b0;
        ib_space_available_i[4] = 1'b1;
        settle();
        check("ib_w4_wid", 64'(fe_warp_id_o), 64'd4);
        check("ib_w4_pc", 64'(fe_pc_o), 64'h400);
        tick();
        settle();
        check("ib_w6_again_wid", 64'(fe_warp_id_o), 64'd6);
        check("ib_w6_again_pc", 64'(fe_pc_o), 64'h604);
        tick();
        settle();
        check("ib_all_waiting", 64'(fe_valid_o), 64'd0);
        dec(3'd4, 32'h0, 32'h0, 1'b1);
        tick();
        dec(3'd6, 32'h0, 32'h0, 1'b1);
        tick();
        dec_valid_i = 1'b0;
        tick();
        settle();
        check("ib_busy_end", 64'(busy_o), 64'd0);

        // Reset while a request is locked
        fe_ready_i = 1'b0;
        launch(3'd3, 32'h300, 32'hFFFF_FFFF);
        tick();
        launch_valid_i = 1'b0;
        settle();
        check("rs_fe_valid_pre", 64'(fe_valid_o), 64'd1);
        tick();
        rst_i = 1'b1;
        #1;
        check("rs_fe_valid", 64'(fe_valid_o), 64'd0);
        check("rs_busy", 64'(busy_o), 64'd0);
        check("rs_launch_ready", 64'(launch_ready_o), 64'd1);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        fe_ready_i = 1'b1;
        launch(3'd0, 32'h40, 32'hFFFF_FFFF);
        tick();
        launch_valid_i = 1'b0;
        settle();
        check("rs_l0_valid", 64'(fe_valid_o), 64'd1);
        check("rs_l0_wid", 64'(fe_warp_id_o), 64'd0);
        check("rs_l0_pc", 64'(fe_pc_o), 64'h40);
        tick();
        settle();
        check("rs_l0_taken", 64'(fe_valid_o), 64'd0);
        check("rs_l0_busy", 64'(busy_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
